// File: rtl/dispatch_ctl.sv
// Dispatch controller: credit-based issue of decoded instructions into ALU/LS
// reservation stations and the ROB, with branch-wait, flush and halt handling.
package dispatch_ctl_pkg;
  typedef enum logic {FU_ALU = 1'b0, FU_LS = 1'b1} fu_t;
endpackage

`ifndef DEBUG
`define DEBUG(msg)
`endif

module dispatch_ctl
  import dispatch_ctl_pkg::*;
#(
  parameter int unsigned ALU_RS_DEPTH = 4,
  parameter int unsigned LS_RS_DEPTH  = 4,
  parameter int unsigned ROB_DEPTH    = 16
) (
  input  logic                               in_clk,
  input  logic                               in_rst_n,
  input  logic                               in_dec_valid,
  input  fu_t                                in_dec_fu_id,
  input  logic                               in_dec_mispredict,
  input  logic                               in_dec_hlt,
  input  logic                               in_alu_free,
  input  logic                               in_ls_free,
  input  logic                               in_rob_free,
  input  logic                               in_branch_resolved,
  input  logic                               in_flush,
  output logic                               out_ready,
  output logic                               out_alu_dispatch,
  output logic                               out_ls_dispatch,
  output logic                               out_rob_alloc,
  output logic [$clog2(ALU_RS_DEPTH+1)-1:0]  out_alu_credits,
  output logic [$clog2(LS_RS_DEPTH+1)-1:0]   out_ls_credits,
  output logic [$clog2(ROB_DEPTH+1)-1:0]     out_rob_credits,
  output logic [1:0]                         out_state,
  output logic [31:0]                        out_stall_cycles,
  output logic                               out_err
);

  localparam int unsigned ACW = $clog2(ALU_RS_DEPTH + 1);
  localparam int unsigned LCW = $clog2(LS_RS_DEPTH + 1);
  localparam int unsigned RCW = $clog2(ROB_DEPTH + 1);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_BR_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_HALTED  = 2'd3;

  // A free that would push a full counter past its depth is absorbed here and
  // reported separately as an overflow.
  function automatic logic [31:0] cred_next(input logic [31:0] cur, input logic [31:0] depth,
                                            input logic take, input logic give, input logic reload);
    logic [31:0] nxt;
    if (reload) begin
      nxt = depth;
    end else if (take && !give) begin
      nxt = cur - 32'd1;
    end else if (give && !take && (cur != depth)) begin
      nxt = cur + 32'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  function automatic logic cred_ovf(input logic [31:0] cur, input logic [31:0] depth,
                                    input logic take, input logic give, input logic reload);
    return !reload && give && !take && (cur == depth);
  endfunction

  logic [1:0]     state_q, state_d;
  logic [ACW-1:0] alu_credits_q, alu_credits_d;
  logic [LCW-1:0] ls_credits_q, ls_credits_d;
  logic [RCW-1:0] rob_credits_q, rob_credits_d;
  logic [31:0]    stall_q, stall_d;
  logic           err_q, err_d;

  logic unit_ok_s, flush_take_s, fire_s, reload_s, ovf_s;
  logic alu_fire_s, ls_fire_s;

  always_comb begin
    unit_ok_s    = (in_dec_fu_id == FU_ALU) ? (alu_credits_q != {ACW{1'b0}})
                                            : (ls_credits_q != {LCW{1'b0}});
    out_ready    = (state_q == ST_RUN) && (rob_credits_q != {RCW{1'b0}}) && unit_ok_s;
    flush_take_s = in_flush && ((state_q == ST_RUN) || (state_q == ST_BR_WAIT));
    // Strobes are forced low while reset is held.
    fire_s       = in_rst_n && in_dec_valid && out_ready && !flush_take_s;
    alu_fire_s   = fire_s && (in_dec_fu_id == FU_ALU);
    ls_fire_s    = fire_s && (in_dec_fu_id == FU_LS);
    reload_s     = (state_q == ST_FLUSH);
  end

  assign out_alu_dispatch = alu_fire_s;
  assign out_ls_dispatch  = ls_fire_s;
  assign out_rob_alloc    = fire_s;

  always_comb begin
    alu_credits_d = ACW'(cred_next(32'(alu_credits_q), 32'(ALU_RS_DEPTH), alu_fire_s, in_alu_free, reload_s));
    ls_credits_d  = LCW'(cred_next(32'(ls_credits_q), 32'(LS_RS_DEPTH), ls_fire_s, in_ls_free, reload_s));
    rob_credits_d = RCW'(cred_next(32'(rob_credits_q), 32'(ROB_DEPTH), fire_s, in_rob_free, reload_s));
    ovf_s = cred_ovf(32'(alu_credits_q), 32'(ALU_RS_DEPTH), alu_fire_s, in_alu_free, reload_s)
          | cred_ovf(32'(ls_credits_q), 32'(LS_RS_DEPTH), ls_fire_s, in_ls_free, reload_s)
          | cred_ovf(32'(rob_credits_q), 32'(ROB_DEPTH), fire_s, in_rob_free, reload_s);
    err_d = err_q | ovf_s;
    if (in_dec_valid && !out_ready) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush_take_s) begin
          state_d = ST_FLUSH;
        end else if (fire_s && in_dec_mispredict) begin
          state_d = ST_BR_WAIT;
        end else if (fire_s && in_dec_hlt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_BR_WAIT: begin
        if (flush_take_s) begin
          state_d = ST_FLUSH;
        end else if (in_branch_resolved) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_BR_WAIT;
        end
      end
      ST_FLUSH:  state_d = ST_RUN;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q       <= ST_RUN;
      alu_credits_q <= ACW'(ALU_RS_DEPTH);
      ls_credits_q  <= LCW'(LS_RS_DEPTH);
      rob_credits_q <= RCW'(ROB_DEPTH);
      stall_q       <= 32'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_credits_q <= alu_credits_d;
      ls_credits_q  <= ls_credits_d;
      rob_credits_q <= rob_credits_d;
      stall_q       <= stall_d;
      err_q         <= err_d;
      if (fire_s) `DEBUG("dispatch");
      if (flush_take_s) `DEBUG("flush");
      if (ovf_s) `DEBUG("credit overflow");
    end
  end

  assign out_alu_credits  = alu_credits_q;
  assign out_ls_credits   = ls_credits_q;
  assign out_rob_credits  = rob_credits_q;
  assign out_state        = state_q;
  assign out_stall_cycles = stall_q;
  assign out_err          = err_q;

endmodule

// File: tb/tb_dispatch_ctl.sv
// Randomized and directed bench for dispatch_ctl against a behavioural model.
module tb_dispatch_ctl;
  import dispatch_ctl_pkg::*;

  localparam int AD = 4, LD = 4, RD = 16;

  logic clk = 1'b0;
  logic rst_n, valid, mp, hlt, af, lf, rf, br, fl;
  fu_t  dec_fu;
  logic out_ready, out_alu_dispatch, out_ls_dispatch, out_rob_alloc;
  logic [2:0] out_alu_credits, out_ls_credits;
  logic [4:0] out_rob_credits;
  logic [1:0] out_state;
  logic [31:0] out_stall_cycles;
  logic out_err;

  always #5 clk = ~clk;

  dispatch_ctl #(.ALU_RS_DEPTH(AD), .LS_RS_DEPTH(LD), .ROB_DEPTH(RD)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_dec_valid(valid), .in_dec_fu_id(dec_fu),
    .in_dec_mispredict(mp), .in_dec_hlt(hlt), .in_alu_free(af), .in_ls_free(lf),
    .in_rob_free(rf), .in_branch_resolved(br), .in_flush(fl), .out_ready(out_ready),
    .out_alu_dispatch(out_alu_dispatch), .out_ls_dispatch(out_ls_dispatch),
    .out_rob_alloc(out_rob_alloc), .out_alu_credits(out_alu_credits),
    .out_ls_credits(out_ls_credits), .out_rob_credits(out_rob_credits),
    .out_state(out_state), .out_stall_cycles(out_stall_cycles), .out_err(out_err));

  // Reference model: state 0=RUN 1=BR_WAIT 2=FLUSH 3=HALTED
  int m_alu, m_ls, m_rob, m_st;
  int unsigned m_stall;
  bit m_err;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_alu = AD; m_ls = LD; m_rob = RD; m_st = 0; m_stall = 0; m_err = 0;
  endtask

  task automatic tick();
    bit rdy, flt, fire, at, lt;
    #1;
    rdy  = (m_st == 0) && (m_rob > 0) && ((dec_fu == FU_LS) ? (m_ls > 0) : (m_alu > 0));
    flt  = fl && (m_st == 0 || m_st == 1);
    fire = valid && rdy && !flt;
    at   = fire && (dec_fu == FU_ALU);
    lt   = fire && (dec_fu == FU_LS);
    chk("ready", out_ready, rdy);
    chk("alu_dispatch", out_alu_dispatch, at);
    chk("ls_dispatch", out_ls_dispatch, lt);
    chk("rob_alloc", out_rob_alloc, fire);
    chk("alu_credits", out_alu_credits, m_alu);
    chk("ls_credits", out_ls_credits, m_ls);
    chk("rob_credits", out_rob_credits, m_rob);
    chk("state", out_state, m_st);
    chk("stall_cycles", out_stall_cycles, m_stall);
    chk("err", out_err, m_err);
    @(posedge clk);
    if (valid && !rdy) m_stall++;
    if (m_st == 2) begin
      m_alu = AD; m_ls = LD; m_rob = RD; m_st = 0;
    end else begin
      m_alu += int'(af) - int'(at);
      m_ls  += int'(lf) - int'(lt);
      m_rob += int'(rf) - int'(fire);
      if (m_alu > AD) begin m_alu = AD; m_err = 1; end
      if (m_ls > LD)  begin m_ls = LD;  m_err = 1; end
      if (m_rob > RD) begin m_rob = RD; m_err = 1; end
      if (flt) m_st = 2;
      else if (m_st == 0 && fire && mp) m_st = 1;
      else if (m_st == 0 && fire && hlt) m_st = 3;
      else if (m_st == 1 && br) m_st = 0;
    end
    @(negedge clk);
  endtask

  task automatic drv(input bit v, input fu_t f, input bit m, input bit h, input bit a_f,
                     input bit l_f, input bit r_f, input bit b, input bit flu);
    valid = v; dec_fu = f; mp = m; hlt = h; af = a_f; lf = l_f; rf = r_f; br = b; fl = flu;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b1; dec_fu = FU_ALU;
    mp = 0; hlt = 0; af = 0; lf = 0; rf = 0; br = 0; fl = 0;
    model_reset();
    #1;
    chk("rst_alu_dispatch", out_alu_dispatch, 32'd0);
    chk("rst_rob_alloc", out_rob_alloc, 32'd0);
    chk("rst_alu_credits", out_alu_credits, AD);
    chk("rst_ls_credits", out_ls_credits, LD);
    chk("rst_rob_credits", out_rob_credits, RD);
    chk("rst_state", out_state, 32'd0);
    chk("rst_stall", out_stall_cycles, 32'd0);
    chk("rst_err", out_err, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = 0; dec_fu = FU_ALU; mp = 0; hlt = 0;
    af = 0; lf = 0; rf = 0; br = 0; fl = 0;
    @(negedge clk);

    // Five ALU valids with no frees: four dispatch, fifth held.
    do_reset();
    for (int i = 0; i < 5; i++) drv(1, FU_ALU, 0, 0, 0, 0, 0, 0, 0);
    chk("r34_alu_credits", out_alu_credits, 32'd0);
    chk("r34_stall", out_stall_cycles, 32'd1);
    drv(1, FU_ALU, 0, 0, 1, 0, 0, 0, 0);
    drv(1, FU_ALU, 0, 0, 0, 0, 0, 0, 0);
    chk("r35_alu_credits", out_alu_credits, 32'd0);

    // Indirect branch wait, then resolve releases pending LS valids.
    do_reset();
    drv(1, FU_LS, 1, 0, 0, 0, 0, 0, 0);
    chk("r36_state_br", out_state, 32'd1);
    for (int i = 0; i < 3; i++) drv(1, FU_LS, 0, 0, 0, 0, 0, 0, 0);
    drv(1, FU_LS, 0, 0, 0, 0, 0, 1, 0);
    chk("r36_state_run", out_state, 32'd0);
    drv(1, FU_LS, 0, 0, 0, 0, 0, 0, 0);

    // Flush with simultaneous resolve in BR_WAIT (ALU=2, ROB=10).
    do_reset();
    drv(1, FU_ALU, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv(1, FU_LS, 0, 0, 0, 1, 0, 0, 0);
    drv(1, FU_ALU, 1, 0, 0, 0, 0, 0, 0);
    chk("r37_alu_credits", out_alu_credits, 32'd2);
    chk("r37_rob_credits", out_rob_credits, 32'd10);
    drv(0, FU_ALU, 0, 0, 0, 0, 0, 1, 1);
    chk("r37_state_flush", out_state, 32'd2);
    drv(0, FU_ALU, 0, 0, 1, 1, 1, 0, 0);
    chk("r37_rob_reload", out_rob_credits, 32'd16);
    chk("r37_state_run", out_state, 32'd0);

    // Halt ignores flush and valids until reset.
    do_reset();
    drv(1, FU_ALU, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drv(1, FU_LS, 0, 0, 0, 0, 0, 1, 1);
    chk("r38_state_halted", out_state, 32'd3);
    do_reset();

    // Spurious free at full credits sets a sticky error.
    drv(0, FU_LS, 0, 0, 0, 1, 0, 0, 0);
    chk("r39_ls_credits", out_ls_credits, 32'd4);
    chk("r39_err", out_err, 32'd1);
    drv(0, FU_LS, 0, 0, 0, 0, 0, 0, 1);
    drv(0, FU_LS, 0, 0, 0, 0, 0, 0, 0);
    chk("r39_err_after_flush", out_err, 32'd1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bit v, m, h, a_f, l_f, r_f, b, flu;
      fu_t f;
      if ((m_st == 3 && $urandom_range(0, 7) == 0) || $urandom_range(0, 149) == 0) do_reset();
      v   = $urandom_range(0, 3) != 0;
      f   = fu_t'($urandom_range(0, 1));
      m   = $urandom_range(0, 7) == 0;
      h   = !m && ($urandom_range(0, 99) == 0);
      a_f = (m_alu < AD) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
      l_f = (m_ls < LD)  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
      r_f = (m_rob < RD) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 59) == 0);
      b   = $urandom_range(0, 3) == 0;
      flu = $urandom_range(0, 29) == 0;
      drv(v, f, m, h, a_f, l_f, r_f, b, flu);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dispatch_ctl.md
DISPATCH_CTL -- requirements
Module: dispatch_ctl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named in_clk and in_rst_n.
REQ-002 Parameter ALU_RS_DEPTH, 4, ALU reservation-station entries.
REQ-003 Parameter LS_RS_DEPTH, 4, load/store reservation-station entries.
REQ-004 Parameter ROB_DEPTH, 16, reorder-buffer entries.
REQ-005 in_clk  input  1  clock, all state on posedge.
REQ-006 in_rst_n  input  1  async active-low reset.
REQ-007 in_dec_valid  input  1  decoded instruction present this cycle.
REQ-008 in_dec_fu_id  input  fu_t  target unit (FU_ALU or FU_LS).
REQ-009 in_dec_mispredict  input  1  instruction is an indirect branch (BR/BLR).
REQ-010 in_dec_hlt  input  1  instruction is HLT.
REQ-011 in_alu_free, in_ls_free, in_rob_free  input  1 each  one-entry release pulses.
REQ-012 in_branch_resolved  input  1  indirect-branch target known.
REQ-013 in_flush  input  1  pipeline squash.
REQ-014 out_ready  output  1  decode may hand over this cycle (combinational).
REQ-015 out_alu_dispatch, out_ls_dispatch, out_rob_alloc  output  1 each  dispatch strobes (combinational).
REQ-016 out_alu_credits, out_ls_credits, out_rob_credits  output  $clog2(DEPTH+1) each  free entries.
REQ-017 out_state  output  2  RUN=0, BR_WAIT=1, FLUSH=2, HALTED=3.
REQ-018 out_stall_cycles  output  32  count of blocked cycles.
REQ-019 out_err  output  1  sticky credit-overflow flag.

Function
REQ-020 out_ready SHALL be 1 iff state==RUN, out_rob_credits>0, and the credit of the unit selected by in_dec_fu_id is >0.
REQ-021 A dispatch fires when in_dec_valid & out_ready; it asserts out_rob_alloc plus exactly one of out_alu_dispatch/out_ls_dispatch in the same cycle, with zero added latency.
REQ-022 Each credit counter SHALL update next = cur - dispatch + free in one cycle; simultaneous dispatch and free leave it unchanged.
REQ-023 A free pulse arriving with the counter at DEPTH (and no same-cycle dispatch) SHALL leave it at DEPTH and set out_err, which stays set until reset.
REQ-024 RUN -> BR_WAIT when the firing instruction has in_dec_mispredict=1.
REQ-025 RUN -> HALTED when the firing instruction has in_dec_hlt=1; HALTED is left only by reset.
REQ-026 BR_WAIT -> RUN on in_branch_resolved; in_branch_resolved in any other state SHALL be ignored.
REQ-027 in_flush in RUN or BR_WAIT SHALL force FLUSH next cycle and suppress any same-cycle dispatch; flush has priority over resolve and over dispatch transitions.
REQ-028 In FLUSH, all credits SHALL load DEPTH values at the next edge, free pulses are ignored, and the state returns to RUN after exactly one cycle.
REQ-029 in_flush in HALTED SHALL be ignored.
REQ-030 out_stall_cycles SHALL increment (wrapping at 2^32) each cycle in_dec_valid=1 and out_ready=0.
REQ-031 Every dispatch, flush or error path SHALL be reported through the `DEBUG macro.

Reset
REQ-032 On in_rst_n=0, asynchronously: state=RUN, credits=ALU_RS_DEPTH/LS_RS_DEPTH/ROB_DEPTH, out_stall_cycles=0, out_err=0; dispatch strobes SHALL be 0 while in reset.
REQ-033 Reset asserted mid-BR_WAIT, FLUSH or HALTED SHALL return the block to the REQ-032 values with no residual pending branch.

Verification
REQ-034 Five back-to-back ALU valids, no frees -> four dispatches; ALU credits 4,3,2,1,0; fifth held with out_ready=0; out_stall_cycles=1 per held cycle.
REQ-035 ALU credits=0, in_alu_free pulse while an ALU valid is waiting -> out_ready=1 the next cycle, dispatch fires, credits remain 0.
REQ-036 BR dispatched -> state=1, out_ready=0 for 3 cycles with LS valids pending; in_branch_resolved -> state=0, LS dispatch the following cycle.
REQ-037 In BR_WAIT with credits ALU=2, ROB=10: assert in_flush and in_branch_resolved together -> state=2, then credits 4/4/16 and state=0.
REQ-038 HLT dispatched -> state=3; in_flush and valids ignored for 10 cycles; in_rst_n low -> all REQ-032 values.
REQ-039 With LS credits at 4, a spurious in_ls_free -> credits stay 4, out_err=1 and remains 1 after a subsequent flush.
